// File: rtl/data_io_stream.sv
// data_io_stream: oversampled SPI download front-end that packs payload
// bytes into words, buffers them in a FIFO and drives the ioctl write port.
module data_io_stream #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 25,
  parameter int         FIFO_DEPTH = 8,
  parameter bit         BIG_ENDIAN = 1'b0,
  parameter logic [7:0] ACK_BYTE   = 8'h4B
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic                          SPI_SCK,
  input  logic                          SPI_SS2,
  input  logic                          SPI_DI,
  output wire                           SPI_DO,
  output logic                          ioctl_download,
  output logic [7:0]                    ioctl_index,
  output logic                          ioctl_wr,
  output logic [ADDR_WIDTH-1:0]         ioctl_addr,
  output logic [DATA_WIDTH-1:0]         ioctl_dout,
  output logic [DATA_WIDTH/8-1:0]       ioctl_be,
  input  logic                          ioctl_wait,
  output logic [31:0]                   ioctl_filesize,
  output logic                          ioctl_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int LW = FA + 1;
  localparam int EW = DATA_WIDTH + NB;

  logic [1:0] sck_s;
  logic [1:0] ss_s;
  logic [1:0] di_s;
  logic       sck_d;
  logic       ss_d;

  // SS2 synchronisers reset high so MISO starts released
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_s <= 2'b00;
      ss_s  <= 2'b11;
      di_s  <= 2'b00;
      sck_d <= 1'b0;
      ss_d  <= 1'b1;
    end else begin
      sck_s <= {sck_s[0], SPI_SCK};
      ss_s  <= {ss_s[0], SPI_SS2};
      di_s  <= {di_s[0], SPI_DI};
      sck_d <= sck_s[1];
      ss_d  <= ss_s[1];
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic ss_idle;

  assign sck_rise = sck_s[1] & ~sck_d;
  assign sck_fall = ~sck_s[1] & sck_d;
  assign ss_idle  = ss_s[1] | ss_d;

  logic [6:0] rx_sh;
  logic [2:0] bit_cnt;
  logic [2:0] byte_cnt;
  logic [7:0] tx_sh;
  logic [7:0] cmd;
  logic       do_bit;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte   = {rx_sh, di_s[1]};
  assign byte_done = sck_rise & ~ss_idle & (bit_cnt == 3'd7);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rx_sh    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sh    <= '0;
      cmd      <= '0;
      do_bit   <= 1'b0;
    end else if (ss_idle) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sh    <= '0;
      do_bit   <= 1'b0;
    end else begin
      if (sck_rise) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done && byte_cnt != 3'd7)
          byte_cnt <= byte_cnt + 3'd1;
        if (byte_done && byte_cnt == 3'd0)
          cmd <= rx_byte;
      end
      // first falling edge of a byte loads the reply
      if (sck_fall) begin
        if (bit_cnt == 3'd0) begin
          if (cmd == 8'h00) begin
            do_bit <= ACK_BYTE[7];
            tx_sh  <= {ACK_BYTE[6:0], 1'b0};
          end else begin
            do_bit <= 1'b0;
            tx_sh  <= '0;
          end
        end else begin
          do_bit <= tx_sh[7];
          tx_sh  <= {tx_sh[6:0], 1'b0};
        end
      end
    end
  end

  assign SPI_DO = ss_s[1] ? 1'bz : do_bit;

  logic is_cmd;
  logic is_arg;
  logic c60;
  logic c61;
  logic c62;
  logic payload;

  assign is_cmd  = byte_done & (byte_cnt == 3'd0);
  assign is_arg  = byte_done & (byte_cnt != 3'd0);
  assign c60     = is_cmd & (rx_byte == 8'h60);
  assign c61     = is_cmd & (rx_byte == 8'h61);
  assign c62     = is_cmd & (rx_byte == 8'h62);
  assign payload = is_arg & (cmd == 8'h61);

  logic [PW-1:0]         pack_cnt;
  logic [PW-1:0]         lane;
  logic [DATA_WIDTH-1:0] pack_word;
  logic [DATA_WIDTH-1:0] word_ins;
  logic [NB-1:0]         pack_be;
  logic [NB-1:0]         be_ins;
  logic                  pack_full;

  assign lane      = BIG_ENDIAN ? PW'(NB - 1) - pack_cnt : pack_cnt;
  assign pack_full = (pack_cnt == PW'(NB - 1));

  always_comb begin
    word_ins = pack_word;
    be_ins   = pack_be;
    for (int i = 0; i < NB; i++) begin
      if (lane == PW'(i)) begin
        word_ins[8*i +: 8] = rx_byte;
        be_ins[i]          = 1'b1;
      end
    end
  end

  logic          flush;
  logic          push_req;
  logic [EW-1:0] push_data;

  assign flush     = c62 & (pack_be != '0);
  assign push_req  = (payload & pack_full) | flush;
  assign push_data = flush ? {pack_be, pack_word}
                           : {be_ins, word_ins};

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [FA-1:0]         wptr;
  logic [FA-1:0]         rptr;
  logic [LW-1:0]         cnt;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  ending;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(FIFO_DEPTH));
  // one pop every other cycle; the write strobe occupies the gap
  assign pop     = ~empty & ~ioctl_wait & ~ioctl_wr;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  assign fifo_level = cnt;

  always_ff @(posedge clk_sys) begin
    if (push_ok)
      mem[wptr] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr           <= '0;
      rptr           <= '0;
      cnt            <= '0;
      ioctl_wr       <= 1'b0;
      ioctl_dout     <= '0;
      ioctl_be       <= '0;
      ioctl_addr     <= '0;
      addr_cnt       <= '0;
      ioctl_overflow <= 1'b0;
      pack_cnt       <= '0;
      pack_word      <= '0;
      pack_be        <= '0;
      ioctl_download <= 1'b0;
      ending         <= 1'b0;
      ioctl_index    <= '0;
      ioctl_filesize <= '0;
    end else begin
      ioctl_wr <= pop;
      if (push_ok)
        wptr <= wptr + FA'(1);
      if (pop) begin
        rptr                 <= rptr + FA'(1);
        {ioctl_be, ioctl_dout} <= mem[rptr];
        ioctl_addr           <= addr_cnt;
        addr_cnt             <= addr_cnt + ADDR_WIDTH'(NB);
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: ;
      endcase
      if (drop)
        ioctl_overflow <= 1'b1;
      if (payload) begin
        if (pack_full) begin
          pack_cnt  <= '0;
          pack_word <= '0;
          pack_be   <= '0;
        end else begin
          pack_cnt  <= pack_cnt + PW'(1);
          pack_word <= word_ins;
          pack_be   <= be_ins;
        end
      end
      if (ending && empty && !push_ok) begin
        ioctl_download <= 1'b0;
        ending         <= 1'b0;
      end
      unique case (1'b1)
        c60: begin
          addr_cnt       <= '0;
          pack_cnt       <= '0;
          pack_word      <= '0;
          pack_be        <= '0;
          ioctl_overflow <= 1'b0;
        end
        c61: begin
          ioctl_download <= 1'b1;
          ending         <= 1'b0;
        end
        c62: begin
          ending <= 1'b1;
          if (flush) begin
            pack_cnt  <= '0;
            pack_word <= '0;
            pack_be   <= '0;
          end
        end
        default: ;
      endcase
      if (is_arg && cmd == 8'h55 && byte_cnt == 3'd1)
        ioctl_index <= rx_byte;
      if (is_arg && cmd == 8'h60 && byte_cnt <= 3'd4)
        ioctl_filesize <= {ioctl_filesize[23:0], rx_byte};
    end
  end

endmodule
